// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the CPU front end. It holds
//                the address/instruction word types, the default fetch
//                constants, and the prefetch FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int INSTR_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam addr_t RESET_PC = '0;
    localparam addr_t PC_STEP  = addr_t'(1);

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of fetch entries with registered storage
//                (no fall-through). Flush has priority over push and pop.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk          in   clock
//    rst          in   synchronous active-high reset
//    i_flush      in   empty the FIFO (wins over push/pop)
//    i_push       in   write i_push_entry at the tail
//    i_push_entry in   entry to write
//    i_pop        in   advance the head
//    o_count      out  number of valid entries
//    o_head       out  entry at the head (valid when o_count != 0)
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_entry,
    input  logic                     i_pop,
    output logic [$clog2(DEPTH):0]   o_count,
    output fetch_entry_t             o_head
);

    localparam int                  c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]    c_full  = (c_ptr_w + 1)'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    // Guard against overflow/underflow even though the caller never asks.
    assign w_do_push = i_push && (r_count != c_full);
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues single-outstanding reads to
//                program memory, buffers returned words with their PC in a
//                prefetch FIFO and hands them to the core via valid/ready.
//                A redirect reloads the PC, flushes the FIFO and discards any
//                read still in flight.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk_in              in   system clock
//    rst_in              in   synchronous active-high reset
//    redirect_valid_in   in   load redirect_pc_in and flush (1-cycle pulse)
//    redirect_pc_in      in   new fetch PC
//    pm_addr_out         out  program memory read address
//    pm_read_request_out out  read request, one cycle per read
//    pm_read_valid_in    in   read data valid, once per request
//    pm_read_data_in     in   read data
//    instr_valid_out     out  FIFO head valid
//    instr_out           out  FIFO head instruction
//    instr_pc_out        out  address of the FIFO head instruction
//    instr_ready_in      in   core consumes the head this cycle
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = cpu_pkg::RESET_PC,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP     = cpu_pkg::PC_STEP
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   redirect_valid_in,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_in,
    output logic [ADDR_WIDTH-1:0]  pm_addr_out,
    output logic                   pm_read_request_out,
    input  logic                   pm_read_valid_in,
    input  logic [INSTR_WIDTH-1:0] pm_read_data_in,
    output logic                   instr_valid_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc_out,
    input  logic                   instr_ready_in
);

    localparam int                   c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0]   c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic                   r_outstanding;
    logic                   r_discard;

    logic [c_cnt_w-1:0]     w_count;
    cpu_pkg::fetch_entry_t  w_head;
    cpu_pkg::fetch_entry_t  w_push_entry;
    logic                   w_req;
    logic                   w_resp;
    logic                   w_push;
    logic                   w_pop;

    // A request only issues when the FIFO has room, so the single
    // outstanding response can always be accepted when it returns.
    assign w_req = !rst_in && !r_outstanding && (w_count < c_depth)
                   && !redirect_valid_in;

    // Responses are only meaningful while a read is in flight; anything
    // else (e.g. a straggler that crossed a reset) is ignored.
    assign w_resp = pm_read_valid_in && r_outstanding;
    assign w_push = w_resp && !r_discard && !redirect_valid_in && !rst_in;
    assign w_pop  = instr_valid_out && instr_ready_in;

    assign w_push_entry.pc    = r_fetch_pc;
    assign w_push_entry.instr = pm_read_data_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (redirect_valid_in) begin
            r_fetch_pc <= redirect_pc_in;
            if (w_resp) begin
                // Response lands with the redirect: drop it, nothing left
                // in flight (this also retires an older stale read).
                r_outstanding <= 1'b0;
                r_discard     <= 1'b0;
            end else if (r_outstanding) begin
                r_discard <= 1'b1;
            end
        end else begin
            if (w_req) begin
                r_outstanding <= 1'b1;
            end
            if (w_resp) begin
                r_outstanding <= 1'b0;
                if (r_discard) begin
                    r_discard <= 1'b0;
                end else begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk_in),
        .rst          (rst_in),
        .i_flush      (redirect_valid_in),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head       (w_head)
    );

    // Forced to the reset view while rst_in is high, before the registers
    // have taken their reset values.
    assign pm_addr_out         = rst_in ? RESET_PC : r_fetch_pc;
    assign pm_read_request_out = w_req;
    assign instr_valid_out     = !rst_in && (w_count != '0);
    assign instr_out           = w_head.instr;
    assign instr_pc_out        = w_head.pc;

endmodule
`default_nettype wire
